// File: rtl/rvv_pkg.sv
// Shared definitions for the RVV reduction engine: op/SEW encodings, FSM states
// and the SEW-aware identity and combine functions used by the lane tree and accumulator.
package rvv_pkg;

    localparam int DW = 32;

    localparam logic [2:0] RED_SUM  = 3'd0;
    localparam logic [2:0] RED_AND  = 3'd1;
    localparam logic [2:0] RED_OR   = 3'd2;
    localparam logic [2:0] RED_XOR  = 3'd3;
    localparam logic [2:0] RED_MINU = 3'd4;
    localparam logic [2:0] RED_MIN  = 3'd5;
    localparam logic [2:0] RED_MAXU = 3'd6;
    localparam logic [2:0] RED_MAX  = 3'd7;

    localparam logic [2:0] SEW_8  = 3'd0;
    localparam logic [2:0] SEW_16 = 3'd1;
    localparam logic [2:0] SEW_32 = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } red_state_e;

    function automatic logic [DW-1:0] sew_mask(input logic [2:0] vsew);
        logic [DW-1:0] m;
        case (vsew)
            SEW_8:   m = 32'h0000_00FF;
            SEW_16:  m = 32'h0000_FFFF;
            SEW_32:  m = 32'hFFFF_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    function automatic logic [DW-1:0] sext(input logic [DW-1:0] v, input logic [2:0] vsew);
        logic [DW-1:0] r;
        case (vsew)
            SEW_8:   r = {{24{v[7]}}, v[7:0]};
            SEW_16:  r = {{16{v[15]}}, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Identity for signed min/max is the SEW-bit signed max/min, zero-extended.
    function automatic logic [DW-1:0] ident(input logic [2:0] op, input logic [2:0] vsew);
        logic [DW-1:0] m;
        logic [DW-1:0] r;
        m = sew_mask(vsew);
        case (op)
            RED_AND, RED_MINU: r = m;
            RED_MIN:           r = m >> 1;
            RED_MAX:           r = m ^ (m >> 1);
            default:           r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [DW-1:0] red_op(input logic [2:0] op, input logic [2:0] vsew,
                                             input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] m;
        logic [DW-1:0] am;
        logic [DW-1:0] bm;
        logic signed [DW-1:0] sa;
        logic signed [DW-1:0] sb;
        logic [DW-1:0] r;
        m  = sew_mask(vsew);
        am = a & m;
        bm = b & m;
        sa = sext(am, vsew);
        sb = sext(bm, vsew);
        case (op)
            RED_SUM:  r = am + bm;
            RED_AND:  r = am & bm;
            RED_OR:   r = am | bm;
            RED_XOR:  r = am ^ bm;
            RED_MINU: r = (am < bm) ? am : bm;
            RED_MIN:  r = (sa < sb) ? am : bm;
            RED_MAXU: r = (am > bm) ? am : bm;
            RED_MAX:  r = (sa > sb) ? am : bm;
            default:  r = '0;
        endcase
        return r & m;
    endfunction

endpackage

// File: rtl/rvv_red_tree.sv
// Combinational balanced reduction of 2^NB_LANES SEW-wide lane values.
module rvv_red_tree
    import rvv_pkg::*;
#(
    parameter int NB_LANES = 1,
    parameter int ELEN     = 32
) (
    input  logic [2:0]                   op_i,
    input  logic [2:0]                   vsew_i,
    input  logic [(ELEN<<NB_LANES)-1:0]  lanes_i,
    output logic [ELEN-1:0]              result_o
);

    localparam int LANES = 1 << NB_LANES;

    // Level lv folds pairs (2j, 2j+1) into slot j, halving the live width each level.
    always_comb begin
        logic [ELEN-1:0] t [LANES];
        for (int j = 0; j < LANES; j++) begin
            t[j] = lanes_i[j*ELEN +: ELEN];
        end
        for (int lv = 0; lv < NB_LANES; lv++) begin
            for (int j = 0; j < (LANES >> (lv + 1)); j++) begin
                t[j] = red_op(op_i, vsew_i, t[2*j], t[2*j+1]);
            end
        end
        result_o = t[0];
    end

endmodule

// File: rtl/rvv_red_engine.sv
// Multi-lane, multi-cycle RVV integer reduction engine (vred* family, SEW 8/16/32, v0 masking).
module rvv_red_engine
    import rvv_pkg::*;
#(
    parameter int unsigned VLEN     = 128,
    parameter int          NB_LANES = 1,
    parameter int          ELEN     = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [2:0]       vsew,
    input  logic [16:0]      vl,
    input  logic             vm,
    input  logic [VLEN-1:0]  v0,
    input  logic [ELEN-1:0]  vs1_e0,
    input  logic [VLEN-1:0]  vs2,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [ELEN-1:0]  result
);

    localparam int          LANES = 1 << NB_LANES;
    localparam logic [16:0] STEP  = 17'(LANES);

    red_state_e state_q, state_d;

    logic [2:0]      op_q;
    logic [2:0]      vsew_q;
    logic            vm_q;
    logic [VLEN-1:0] v0_q;
    logic [VLEN-1:0] vs2_q;
    logic [ELEN-1:0] acc_q;
    logic [16:0]     idx_q;
    logic [16:0]     limit_q;
    logic            illegal_q;
    logic [ELEN-1:0] result_q;

    logic                        sew_bad;
    logic [16:0]                 max_el;
    logic [16:0]                 limit_start;
    logic [ELEN-1:0]             vs1_trunc;
    logic                        last_step;
    logic [(ELEN<<NB_LANES)-1:0] lanes;
    logic [ELEN-1:0]             tree_out;
    logic [ELEN-1:0]             acc_next;

    assign sew_bad     = (vsew > SEW_32);
    assign max_el      = 17'(VLEN >> ({2'b00, vsew} + 5'd3));
    assign limit_start = (vl < max_el) ? vl : max_el;
    assign vs1_trunc   = vs1_e0 & sew_mask(vsew);
    assign last_step   = (idx_q + STEP) >= limit_q;
    assign acc_next    = red_op(op_q, vsew_q, acc_q, tree_out);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [16:0]     e;
            logic [21:0]     off;
            logic [ELEN-1:0] elem;
            logic            v0_bit;
            logic            act;
            assign e      = idx_q + 17'(gi);
            assign off    = 22'(e) << ({1'b0, vsew_q[1:0]} + 3'd3);
            assign elem   = ELEN'(vs2_q >> off);
            assign v0_bit = 1'(v0_q >> e);
            // Out-of-range or masked-off lanes feed the op identity so they drop out of the tree.
            assign act    = (e < limit_q) && (vm_q || v0_bit);
            assign lanes[gi*ELEN +: ELEN] = act ? (elem & sew_mask(vsew_q)) : ident(op_q, vsew_q);
        end
    endgenerate

    rvv_red_tree #(
        .NB_LANES (NB_LANES),
        .ELEN     (ELEN)
    ) u_tree (
        .op_i     (op_q),
        .vsew_i   (vsew_q),
        .lanes_i  (lanes),
        .result_o (tree_out)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (sew_bad || (limit_start == 17'd0)) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN:  state_d = last_step ? ST_FIN : ST_RUN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == ST_RUN);
        done    = (state_q == ST_FIN);
        illegal = (state_q == ST_FIN) && illegal_q;
    end

    // result is written on the way into FIN so it is already valid while done is high.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_q      <= '0;
            vsew_q    <= '0;
            vm_q      <= 1'b0;
            v0_q      <= '0;
            vs2_q     <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            limit_q   <= '0;
            illegal_q <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        vsew_q    <= vsew;
                        vm_q      <= vm;
                        v0_q      <= v0;
                        vs2_q     <= vs2;
                        acc_q     <= vs1_trunc;
                        idx_q     <= '0;
                        limit_q   <= limit_start;
                        illegal_q <= sew_bad;
                        if (sew_bad) begin
                            result_q <= '0;
                        end else if (limit_start == 17'd0) begin
                            result_q <= vs1_trunc;
                        end
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_next;
                    idx_q <= idx_q + STEP;
                    if (last_step) begin
                        result_q <= acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;

endmodule
